fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the opcode decoder. It holds the program counter and reads 8-bit opcodes from instruction memory over a request/valid handshake. Each opcode is presented to the decoder through a valid/ready handshake. The unit also applies jumps resolved downstream and stops on the halt opcode.

## Interface
Parameters:
- ADDR_W, 4: program counter / instruction address width (16-entry program space).
- OP_W, 8: opcode width; must match the decoder's `opcode` input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- run  in  1  start/resume pulse; sampled only in IDLE and HALT.
- imem_req  out  ADDR_W-independent 1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals `pc` while `imem_req` is high.
- imem_rdata  in  OP_W  opcode returned by memory.
- imem_valid  in  1  `imem_rdata` is valid this cycle; ignored unless in FETCH.
- opcode  out  OP_W  registered opcode to the decoder.
- opcode_valid  out  1  `opcode` is valid.
- opcode_ready  in  1  downstream consumes `opcode` this cycle.
- jump_en  in  1  take a jump; qualified by the issue handshake.
- jump_addr  in  ADDR_W  jump target.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high while in HALT.

## Operation
- The unit has four states: IDLE, FETCH, ISSUE and HALT.
- IDLE:
  - Goes to FETCH when `run`=1.
  - Otherwise stays in IDLE.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_valid`=1.
  - On `imem_valid`: `opcode` <= `imem_rdata`, then go to ISSUE.
- ISSUE:
  - `opcode_valid`=1.
  - `opcode` is held stable until `opcode_ready`=1.
  - The handshake completes when `opcode_valid` and `opcode_ready` are both 1. On completion:
    - If `opcode`==HLT, go to HALT and set `pc` <= `pc`+1.
    - Otherwise, if `jump_en`=1, set `pc` <= `jump_addr` and go to FETCH.
    - Otherwise, set `pc` <= `pc`+1 and go to FETCH.
  - For HLT, `jump_en` is ignored.
- HALT:
  - `halted`=1 and `imem_req`=0.
  - `run`=1 returns the unit to FETCH at the current `pc`.
- PC arithmetic: unsigned, modulo 2^ADDR_W. With ADDR_W=4, 4'hF+1 wraps to 4'h0. A jump to 4'hF is legal.
- `jump_en` outside a completed ISSUE handshake is ignored and has no side effects.
- `imem_valid` outside FETCH is ignored.
- `opcode_ready` outside ISSUE is ignored.
- `run` in FETCH or ISSUE is ignored.
- Reset values: state=IDLE, `pc`=0, `opcode`=NOP (8'h00), `opcode_valid`=0, `imem_req`=0, `imem_addr`=0, `halted`=0.
- Reset mid-operation: if `rst_n` falls during FETCH or ISSUE, every output takes its reset value immediately (asynchronously). The in-flight fetch is abandoned. A late `imem_valid` after reset is ignored because the state is IDLE.

## Timing
- IDLE with `run`=1 at edge N: FETCH from N, so `imem_req` is high in cycle N+1.
- Zero-wait memory (`imem_valid` in the first FETCH cycle): `opcode_valid` is high in the next cycle.
- Best-case throughput: 2 cycles per instruction, alternating FETCH and ISSUE. There is no prefetch.
- Each additional memory wait cycle adds one cycle; each cycle of `opcode_ready` low adds one cycle.
- `pc` updates on the edge that completes the issue handshake. `imem_addr` shows the new value in the following FETCH cycle.
- All outputs are registered or decoded directly from the state register plus `pc`. There is no combinational path from any input to any output.

## Structure
- Shared instruction header holds:
  - NOP (8'h00) and HLT (8'hFF) opcode constants, alongside the existing MOV opcodes. HLT must not collide with any existing opcode.
  - The state encoding constants (2 bits).
- There is one natural sub-module, `program_counter`: load/increment register with async active-low reset and controls `inc`, `load`, `load_addr`. The remaining FSM stays in `fetch_unit`.
- The decoder connects to `opcode` directly. `opcode_valid` gates the decoder's register-write enables at the top level.

## Test plan
- Reset then `run` pulse, memory returns 8'h01 at addr 0 with zero wait, `opcode_ready`=1 → `imem_addr`=0, `opcode`=8'h01 with `opcode_valid` for 1 cycle, then `pc`=1 and `imem_addr`=1.
- `imem_valid` delayed 3 cycles and `opcode_ready` low 2 cycles → `imem_addr` stable throughout FETCH, `opcode` stable throughout ISSUE, `pc` advances exactly once.
- `jump_en`=1, `jump_addr`=4'hA at the issue handshake → next `imem_addr`=4'hA. `jump_en` pulsed during FETCH → no effect.
- Straight-line run from `pc`=4'hE → issues at addresses E, F, then `pc` wraps to 0.
- HLT (8'hFF) at addr 3 → `halted`=1, `imem_req`=0, `pc`=4. A later `run` pulse → fetch at addr 4.
- `rst_n` low during FETCH with a late `imem_valid` → all outputs at reset values, state IDLE, no opcode issued.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared instruction header: opcodes, widths, fetch FSM encoding
package fetch_unit_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_OP_W   = 8;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_MOV_RI = 8'h10;
  localparam logic [7:0] OP_MOV_RR = 8'h11;
  localparam logic [7:0] OP_HLT    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and opcode issue handshakes of the fetch stage
interface fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [OP_W-1:0]   imem_rdata;
  logic              imem_valid;
  logic [OP_W-1:0]   opcode;
  logic              opcode_valid;
  logic              opcode_ready;

  modport master (
    output imem_req, imem_addr, opcode, opcode_valid,
    input  imem_rdata, imem_valid, opcode_ready
  );

  modport slave (
    input  imem_req, imem_addr, opcode, opcode_valid,
    output imem_rdata, imem_valid, opcode_ready
  );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter register with load and modulo-2^ADDR_W increment
module program_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  // load wins over inc; the FSM never asserts both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: reads opcodes from imem and issues them to the decoder
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  fetch_unit_if.master      bus,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_e          state, state_nxt;
  logic [OP_W-1:0] opcode_q;
  logic            pc_inc, pc_load;

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (jump_addr),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= OP_W'(OP_NOP);
    end else if (state == ST_FETCH && bus.imem_valid) begin
      opcode_q <= bus.imem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        // HLT still advances pc so a resume continues after it, ignoring jump_en
        if (bus.opcode_ready) begin
          if (opcode_q == OP_W'(OP_HLT)) begin
            pc_inc    = 1'b1;
            state_nxt = ST_HALT;
          end else if (jump_en) begin
            pc_load   = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (run) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.imem_req     = (state == ST_FETCH);
  assign bus.imem_addr    = bus.imem_req ? pc : '0;
  assign bus.opcode       = opcode_q;
  assign bus.opcode_valid = (state == ST_ISSUE);
  assign halted           = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = 4'h0;
  logic [3:0] pc;
  logic       halted;

  fetch_unit_if #(.ADDR_W(4), .OP_W(8)) bus ();

  fetch_unit #(.ADDR_W(4), .OP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bus       (bus),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    int         wt;
    int         rlow;
    logic       jen;
    logic [3:0] jaddr;
    logic [3:0] exp_pc;
    logic       exp_halted;
  } vec_t;

  // entered at a negedge with the DUT in FETCH at address `at`
  task automatic issue_one(input vec_t v, input logic [3:0] at);
    chk("fetch_req", 32'(bus.imem_req), 1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(at));
    for (int i = 0; i < v.wt; i++) begin
      bus.imem_valid = 1'b0;
      bus.opcode_ready = 1'b1;
      jump_en = 1'b1;
      jump_addr = 4'h5;
      @(negedge clk);
      chk("fetch_hold_addr", 32'(bus.imem_addr), 32'(at));
      chk("fetch_hold_req", 32'(bus.imem_req), 1);
      chk("fetch_pc", 32'(pc), 32'(at));
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = v.op;
    bus.opcode_ready = 1'b0;
    jump_en = 1'b0;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 8'hA5;
    chk("issue_valid", 32'(bus.opcode_valid), 1);
    chk("issue_op", 32'(bus.opcode), 32'(v.op));
    chk("issue_req", 32'(bus.imem_req), 0);
    for (int i = 0; i < v.rlow; i++) begin
      bus.opcode_ready = 1'b0;
      bus.imem_valid = 1'b1;
      jump_en = 1'b1;
      jump_addr = 4'hC;
      @(negedge clk);
      chk("issue_hold_op", 32'(bus.opcode), 32'(v.op));
      chk("issue_hold_valid", 32'(bus.opcode_valid), 1);
      chk("issue_hold_pc", 32'(pc), 32'(at));
    end
    bus.imem_valid = 1'b0;
    bus.opcode_ready = 1'b1;
    jump_en = v.jen;
    jump_addr = v.jaddr;
    @(negedge clk);
    bus.opcode_ready = 1'b0;
    jump_en = 1'b0;
    chk("next_pc", 32'(pc), 32'(v.exp_pc));
    chk("next_halted", 32'(halted), 32'(v.exp_halted));
    chk("valid_drop", 32'(bus.opcode_valid), 0);
    chk("next_req", 32'(bus.imem_req), 32'(!v.exp_halted));
    if (!v.exp_halted) chk("next_addr", 32'(bus.imem_addr), 32'(v.exp_pc));
  endtask

  initial begin
    vec_t       vecs [10];
    vec_t       rv;
    logic [3:0] at;
    logic [7:0] mem [16];
    logic [3:0] model_pc;
    bit         model_halted;
    bit         hs;
    int         wt;
    int         issued;

    bus.imem_valid = 1'b0;
    bus.imem_rdata = 8'h00;
    bus.opcode_ready = 1'b0;

    vecs[0] = '{8'h01, 0, 0, 1'b0, 4'h0, 4'h1, 1'b0};
    vecs[1] = '{8'h22, 3, 2, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[2] = '{8'h33, 0, 0, 1'b0, 4'h0, 4'h3, 1'b0};
    vecs[3] = '{8'hFF, 0, 0, 1'b1, 4'h9, 4'h4, 1'b1};
    vecs[4] = '{8'h10, 1, 0, 1'b1, 4'hA, 4'hA, 1'b0};
    vecs[5] = '{8'h11, 0, 1, 1'b1, 4'hE, 4'hE, 1'b0};
    vecs[6] = '{8'h05, 2, 0, 1'b0, 4'h0, 4'hF, 1'b0};
    vecs[7] = '{8'h06, 0, 0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[8] = '{8'h07, 0, 0, 1'b1, 4'hF, 4'hF, 1'b0};
    vecs[9] = '{8'hFF, 0, 3, 1'b1, 4'h3, 4'h0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_opcode", 32'(bus.opcode), 0);
    chk("rst_valid", 32'(bus.opcode_valid), 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(bus.imem_req), 0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;

    at = 4'h0;
    for (int i = 0; i < 10; i++) begin
      issue_one(vecs[i], at);
      at = vecs[i].exp_pc;
      if (vecs[i].exp_halted) begin
        bus.imem_valid = 1'b1;
        bus.opcode_ready = 1'b1;
        jump_en = 1'b1;
        @(negedge clk);
        chk("halt_hold", 32'(halted), 1);
        chk("halt_req", 32'(bus.imem_req), 0);
        chk("halt_pc", 32'(pc), 32'(at));
        chk("halt_valid", 32'(bus.opcode_valid), 0);
        bus.imem_valid = 1'b0;
        bus.opcode_ready = 1'b0;
        jump_en = 1'b0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("resume_halted", 32'(halted), 0);
      end
    end

    // asynchronous reset mid-FETCH with a late memory response
    rv = '{8'h44, 0, 0, 1'b1, 4'h7, 4'h7, 1'b0};
    issue_one(rv, at);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 8'h55;
    #1;
    chk("arst_pc", 32'(pc), 0);
    chk("arst_opcode", 32'(bus.opcode), 0);
    chk("arst_valid", 32'(bus.opcode_valid), 0);
    chk("arst_req", 32'(bus.imem_req), 0);
    chk("arst_addr", 32'(bus.imem_addr), 0);
    chk("arst_halted", 32'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_valid_op", 32'(bus.opcode), 0);
      chk("late_valid_issue", 32'(bus.opcode_valid), 0);
      chk("late_valid_req", 32'(bus.imem_req), 0);
    end
    bus.imem_valid = 1'b0;

    // randomized run against an instruction-level model of the program
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? OP_HLT : 8'($urandom_range(0, 254));
    model_pc = 4'h0;
    model_halted = 1'b0;
    issued = 0;
    wt = 0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rand_pc", 32'(pc), 32'(model_pc));
      chk("rand_halted", 32'(halted), 32'(model_halted));
      if (model_halted) begin
        chk("rand_halt_req", 32'(bus.imem_req), 0);
        chk("rand_halt_valid", 32'(bus.opcode_valid), 0);
      end
      if (bus.imem_req) chk("rand_addr", 32'(bus.imem_addr), 32'(model_pc));
      if (bus.opcode_valid) chk("rand_opcode", 32'(bus.opcode), 32'(mem[model_pc]));

      if (bus.imem_req) begin
        if (wt == 0) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          wt = $urandom_range(0, 2);
        end else begin
          bus.imem_valid = 1'b0;
          wt--;
        end
      end else begin
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_rdata = 8'($urandom);
      end
      bus.opcode_ready = ($urandom_range(0, 9) < 7);
      jump_en = 1'($urandom_range(0, 1));
      jump_addr = 4'($urandom);
      run = model_halted ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);

      hs = bus.opcode_valid && bus.opcode_ready;
      if (hs) begin
        issued++;
        if (mem[model_pc] == OP_HLT) begin
          model_pc = model_pc + 4'h1;
          model_halted = 1'b1;
        end else if (jump_en) begin
          model_pc = jump_addr;
        end else begin
          model_pc = model_pc + 4'h1;
        end
      end else if (model_halted && run) begin
        model_halted = 1'b0;
      end
      @(negedge clk);
    end
    chk("rand_progress", 32'(issued >= 40), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
